// File: rtl/test_1_if.sv
// Signal bundle between the snake game logic, the frame-diff scanner and the display engine.
// The master side drives the cell flags and handshakes; the slave side is the scanner.
interface test_1_if;
  logic       snakeHead;
  logic       snakeBody;
  logic       apple;
  logic       border;
  logic       mode_pb;
  logic       GameOver;
  logic       cmd_done;
  logic [3:0] x;
  logic [3:0] y;
  logic [2:0] obj_code;
  logic       diff;
  logic       en_update;
  logic       enable_loop;
  logic       init_cycle;
  logic       sync_reset;

  modport master (
    output snakeHead, snakeBody, apple, border, mode_pb, GameOver, cmd_done,
    input  x, y, obj_code, diff, en_update, enable_loop, init_cycle, sync_reset
  );

  modport slave (
    input  snakeHead, snakeBody, apple, border, mode_pb, GameOver, cmd_done,
    output x, y, obj_code, diff, en_update, enable_loop, init_cycle, sync_reset
  );
endinterface

// File: rtl/test_1.sv
// Frame-diff scanner: walks the grid and stops on every cell whose object differs from the last drawn frame.
// Optional MODE_PB_RESTART_EN: a mode_pb press restarts the scan exactly like a GameOver rising edge.
module test_1 #(
  parameter int GRID_W = 16,
  parameter int GRID_H = 12
) (
  input logic     clk,
  input logic     nrst,
  test_1_if.slave bus
);

  typedef enum logic [1:0] {
    ST_INIT,
    ST_SCAN,
    ST_WAIT
  } state_e;

  localparam logic [3:0] X_LAST = 4'(GRID_W - 1);
  localparam logic [3:0] Y_LAST = 4'(GRID_H - 1);

  state_e     state_q, state_d;
  logic [3:0] x_q, x_d;
  logic [3:0] y_q, y_d;
  logic [2:0] shadow_q [GRID_H][GRID_W];
  logic [2:0] shadow_d [GRID_H][GRID_W];
  logic       game_over_q, game_over_d;
  logic       sync_reset_q, sync_reset_d;

  logic [2:0] obj_code;
  logic [3:0] x_next;
  logic [3:0] y_next;
  logic       mismatch;

`ifdef MODE_PB_RESTART_EN
  logic       mode_pb_q, mode_pb_d;
`else
  logic       mode_pb_unused;
  assign mode_pb_unused = bus.mode_pb;
`endif

  // NOTE: every variable assigned in an always_comb gets a default first, so no path can infer a latch.
  always_comb begin
    obj_code = 3'd0;
    if (bus.snakeHead)      obj_code = 3'd1;
    else if (bus.snakeBody) obj_code = 3'd2;
    else if (bus.apple)     obj_code = 3'd3;
    else if (bus.border)    obj_code = 3'd4;
  end

  // Restart request: registered rising edge, so sync_reset is a clean one-cycle pulse.
  always_comb begin
    game_over_d  = bus.GameOver;
    sync_reset_d = bus.GameOver & ~game_over_q;
`ifdef MODE_PB_RESTART_EN
    mode_pb_d    = bus.mode_pb;
    sync_reset_d = sync_reset_d | (bus.mode_pb & ~mode_pb_q);
`endif
  end

  // Next state, scan position and shadow update.
  always_comb begin
    x_next = (x_q == X_LAST) ? 4'd0 : x_q + 4'd1;
    y_next = y_q;
    if (x_q == X_LAST) y_next = (y_q == Y_LAST) ? 4'd0 : y_q + 4'd1;
    mismatch = (obj_code != shadow_q[y_q][x_q]);

    state_d  = state_q;
    x_d      = x_q;
    y_d      = y_q;
    shadow_d = shadow_q;

    case (state_q)
      ST_INIT: begin
        if (bus.cmd_done) state_d = ST_SCAN;
      end
      ST_SCAN: begin
        if (mismatch) begin
          shadow_d[y_q][x_q] = obj_code;
          state_d            = ST_WAIT;
        end else begin
          x_d = x_next;
          y_d = y_next;
        end
      end
      ST_WAIT: begin
        if (bus.cmd_done) begin
          x_d     = x_next;
          y_d     = y_next;
          state_d = ST_SCAN;
        end
      end
      default: state_d = ST_INIT;
    endcase

    // Restart overrides any handshake in flight, including a pending redraw.
    if (sync_reset_q) begin
      state_d = ST_SCAN;
      x_d     = 4'd0;
      y_d     = 4'd0;
      for (int r = 0; r < GRID_H; r++) begin
        for (int c = 0; c < GRID_W; c++) shadow_d[r][c] = 3'd0;
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments only, so every flop samples pre-edge values.
  // NOTE: the shadow is a flop array, not RAM, so reset and restart can clear all entries in one cycle.
  always_ff @(posedge clk or posedge nrst) begin
    if (nrst) begin
      state_q      <= ST_INIT;
      x_q          <= 4'd0;
      y_q          <= 4'd0;
      game_over_q  <= 1'b0;
      sync_reset_q <= 1'b0;
`ifdef MODE_PB_RESTART_EN
      mode_pb_q    <= 1'b0;
`endif
      for (int r = 0; r < GRID_H; r++) begin
        for (int c = 0; c < GRID_W; c++) shadow_q[r][c] <= 3'd0;
      end
    end else begin
      state_q      <= state_d;
      x_q          <= x_d;
      y_q          <= y_d;
      game_over_q  <= game_over_d;
      sync_reset_q <= sync_reset_d;
`ifdef MODE_PB_RESTART_EN
      mode_pb_q    <= mode_pb_d;
`endif
      shadow_q     <= shadow_d;
    end
  end

  // Status outputs decoded from the registered state only.
  always_comb begin
    bus.init_cycle  = (state_q == ST_INIT);
    bus.enable_loop = (state_q == ST_SCAN);
    bus.diff        = (state_q == ST_WAIT);
    bus.en_update   = (state_q == ST_WAIT);
  end

  assign bus.x          = x_q;
  assign bus.y          = y_q;
  assign bus.obj_code   = obj_code;
  assign bus.sync_reset = sync_reset_q;

endmodule

// File: tb/tb_test_1.sv
// Directed bench for test_1: a small game model drives cell flags from x/y, a display model answers cmd_done.
// Build with MODE_PB_RESTART_EN defined to expect a mode_pb restart.
module tb_test_1;

  logic clk = 1'b0;
  logic nrst;

  test_1_if bus ();

  test_1 dut (
    .clk  (clk),
    .nrst (nrst),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // Game model configuration
  bit border_on;
  bit head_on;
  bit body_on;
  bit apple_on;
  int head_x, head_y;
  int body_x, body_y;
  int apple_x, apple_y;

  // Per-frame record of redraw requests
  bit seen    [12][16];
  int code_at [12][16];

  always_comb begin
    bus.snakeHead = head_on  && (int'(bus.x) == head_x)  && (int'(bus.y) == head_y);
    bus.snakeBody = body_on  && (int'(bus.x) == body_x)  && (int'(bus.y) == body_y);
    bus.apple     = apple_on && (int'(bus.x) == apple_x) && (int'(bus.y) == apple_y);
    bus.border    = border_on && (bus.x == 4'd0 || bus.x == 4'd15 || bus.y == 4'd0 || bus.y == 4'd11);
  end

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Runs the scanner until it wraps from (15,11) to (0,0), answering every redraw request.
  // hold > 0 delays cmd_done on the first request and checks that the scanner holds the cell.
  task automatic run_frame(input int hold, output int ndiff, output int ncyc);
    int px, py;
    bit done, first;
    ndiff = 0;
    ncyc  = 0;
    done  = 1'b0;
    first = 1'b1;
    for (int r = 0; r < 12; r++) begin
      for (int c = 0; c < 16; c++) begin
        seen[r][c]    = 1'b0;
        code_at[r][c] = 0;
      end
    end
    px = int'(bus.x);
    py = int'(bus.y);
    while (!done && ncyc < 2000) begin
      @(negedge clk);
      ncyc++;
      if (bus.diff) begin
        seen[bus.y][bus.x]    = 1'b1;
        code_at[bus.y][bus.x] = int'(bus.obj_code);
        ndiff++;
        if (first && hold > 0) begin
          check("first_diff_x", int'(bus.x), 0);
          check("first_diff_y", int'(bus.y), 0);
          check("first_diff_code", int'(bus.obj_code), 4);
          check("first_en_update", int'(bus.en_update), 1);
          repeat (hold) begin
            @(negedge clk);
            ncyc++;
          end
          check("hold_x", int'(bus.x), 0);
          check("hold_y", int'(bus.y), 0);
          check("hold_diff", int'(bus.diff), 1);
        end
        first = 1'b0;
        bus.cmd_done = 1'b1;
        @(negedge clk);
        ncyc++;
        bus.cmd_done = 1'b0;
      end
      if (px == 15 && py == 11 && bus.x == 4'd0 && bus.y == 4'd0) done = 1'b1;
      px = int'(bus.x);
      py = int'(bus.y);
    end
    if (!done) check("frame_wrap_timeout", 0, 1);
  endtask

  initial begin
    int nd, nc, k;

    nrst         = 1'b1;
    bus.cmd_done = 1'b0;
    bus.GameOver = 1'b0;
    bus.mode_pb  = 1'b0;
    border_on = 1'b0; head_on = 1'b0; body_on = 1'b0; apple_on = 1'b0;
    head_x = 0; head_y = 0; body_x = 0; body_y = 0; apple_x = 0; apple_y = 0;

    // Power-on reset
    repeat (5) @(negedge clk);
    check("rst_x", int'(bus.x), 0);
    check("rst_y", int'(bus.y), 0);
    check("rst_init_cycle", int'(bus.init_cycle), 1);
    check("rst_enable_loop", int'(bus.enable_loop), 0);
    check("rst_diff", int'(bus.diff), 0);
    check("rst_en_update", int'(bus.en_update), 0);
    check("rst_sync_reset", int'(bus.sync_reset), 0);

    // INIT holds without cmd_done, then one pulse enters SCAN on an empty grid
    nrst = 1'b0;
    repeat (2) @(negedge clk);
    check("init_hold", int'(bus.init_cycle), 1);
    check("init_hold_x", int'(bus.x), 0);
    bus.cmd_done = 1'b1;
    @(negedge clk);
    bus.cmd_done = 1'b0;
    check("init_done_init_cycle", int'(bus.init_cycle), 0);
    check("init_done_enable_loop", int'(bus.enable_loop), 1);
    check("init_done_x", int'(bus.x), 0);
    @(negedge clk);
    check("first_advance_x", int'(bus.x), 1);
    run_frame(0, nd, nc);
    check("empty_frame_diffs", nd, 0);

    // Frame 1: border ring plus head at (4,4)
    border_on = 1'b1;
    head_on = 1'b1; head_x = 4; head_y = 4;
    run_frame(3, nd, nc);
    check("frame1_diffs", nd, 53);
    check("frame1_cycles", nc, 248);
    check("frame1_head_seen", int'(seen[4][4]), 1);
    check("frame1_head_code", code_at[4][4], 1);
    check("frame1_corner_code", code_at[11][15], 4);

    // Frame 2: identical, no redraw, exactly one cell per cycle and a clean wrap
    run_frame(0, nd, nc);
    check("frame2_diffs", nd, 0);
    check("frame2_cycles", nc, 192);
    check("frame2_wrap_x", int'(bus.x), 0);
    check("frame2_wrap_y", int'(bus.y), 0);

    // Frame 3: head moves to (5,4) with apple on the same cell, body at (4,4)
    head_x = 5;
    body_on = 1'b1; body_x = 4; body_y = 4;
    apple_on = 1'b1; apple_x = 5; apple_y = 4;
    run_frame(0, nd, nc);
    check("frame3_diffs", nd, 2);
    check("frame3_body_seen", int'(seen[4][4]), 1);
    check("frame3_body_code", code_at[4][4], 2);
    check("frame3_head_seen", int'(seen[4][5]), 1);
    check("frame3_head_over_apple", code_at[4][5], 1);

    // Restart in the middle of a pending redraw; cmd_done during sync_reset must not win
    head_x = 6; body_x = 5; apple_on = 1'b0;
    k = 0;
    while (!bus.diff && k < 400) begin
      @(negedge clk);
      k++;
    end
    check("restart_wait_diff", int'(bus.diff), 1);
    check("restart_wait_x", int'(bus.x), 4);
    check("restart_wait_y", int'(bus.y), 4);
    bus.GameOver = 1'b1;
    @(negedge clk);
    check("restart_pulse", int'(bus.sync_reset), 1);
    check("restart_pulse_diff", int'(bus.diff), 1);
    bus.cmd_done = 1'b1;
    @(negedge clk);
    bus.cmd_done = 1'b0;
    check("restart_pulse_end", int'(bus.sync_reset), 0);
    check("restart_x", int'(bus.x), 0);
    check("restart_y", int'(bus.y), 0);
    check("restart_diff", int'(bus.diff), 0);
    check("restart_enable_loop", int'(bus.enable_loop), 1);
    bus.GameOver = 1'b0;
    run_frame(0, nd, nc);
    check("redraw_diffs", nd, 54);
    check("redraw_body_code", code_at[4][5], 2);
    check("redraw_head_code", code_at[4][6], 1);

    // mode_pb press mid-frame on an unchanged grid
    k = 0;
    while (!(bus.x == 4'd8 && bus.y == 4'd5) && k < 400) begin
      @(negedge clk);
      k++;
    end
    check("mode_pb_reach_x", int'(bus.x), 8);
    bus.mode_pb = 1'b1;
    @(negedge clk);
    bus.mode_pb = 1'b0;
`ifdef MODE_PB_RESTART_EN
    check("mode_pb_sync_reset", int'(bus.sync_reset), 1);
    @(negedge clk);
    check("mode_pb_x", int'(bus.x), 0);
    check("mode_pb_y", int'(bus.y), 0);
`else
    check("mode_pb_sync_reset", int'(bus.sync_reset), 0);
    @(negedge clk);
    check("mode_pb_x", int'(bus.x), 10);
    check("mode_pb_y", int'(bus.y), 5);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
